// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, 1-cycle synchronous imem read, one issue per cycle,
// redirect/stall handling with a 1-entry skid buffer. Define STATIC_JMP_EN to predecode JMP.
module instr_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [3:0]         opcode,
  output logic [INSTR_W-5:0] operand,
  output logic [ADDR_W-1:0]  issue_pc,
  output logic               issue_valid
);

  localparam int OPND_W = INSTR_W - 4;
  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {BOOT, RUN, BUBBLE, HOLD} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic               skid_valid;
  logic [INSTR_W-1:0] skid_data;
  logic [ADDR_W-1:0]  skid_pc;

  logic               src_valid;
  logic [INSTR_W-1:0] src_word;
  logic [ADDR_W-1:0]  src_pc;

  // The word entering issue: the skid entry when leaving HOLD, otherwise the memory return.
  always_comb begin
    src_valid = 1'b0;
    src_word  = imem_rdata;
    src_pc    = imem_addr;
    if (state == HOLD) begin
      src_valid = skid_valid;
      src_word  = skid_data;
      src_pc    = skid_pc;
    end else if (state == RUN) begin
      src_valid = 1'b1;
    end
  end

`ifdef STATIC_JMP_EN
  logic              take_jmp;
  logic [ADDR_W-1:0] jmp_target;
  assign take_jmp   = src_valid && (src_word[INSTR_W-1 -: 4] == 4'hF);
  assign jmp_target = src_word[ADDR_W-1:0];
`endif

  // Skid payload needs no reset: skid_valid qualifies it.
  always_ff @(posedge clk) begin
    if (state != BOOT && state != HOLD && !redirect && stall) begin
      skid_data <= imem_rdata;
      skid_pc   <= imem_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= PC_RST;
      imem_en     <= 1'b0;
      imem_addr   <= PC_RST;
      opcode      <= 4'd0;
      operand     <= '0;
      issue_pc    <= '0;
      issue_valid <= 1'b0;
      skid_valid  <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          imem_en   <= 1'b1;
          imem_addr <= pc;
          pc        <= pc + 1'b1;
          state     <= RUN;
        end
        default: begin
          if (redirect) begin
            imem_en     <= 1'b1;
            imem_addr   <= redirect_pc;
            pc          <= redirect_pc + 1'b1;
            skid_valid  <= 1'b0;
            opcode      <= 4'd0;
            operand     <= '0;
            issue_valid <= 1'b0;
            state       <= RUN;
          end else if (stall) begin
            // Outputs freeze; only the first stall cycle captures the in-flight word.
            imem_en <= 1'b0;
            if (state != HOLD) begin
              skid_valid <= imem_en;
              state      <= HOLD;
            end
          end else begin
            skid_valid <= 1'b0;
            if (src_valid) begin
              opcode      <= src_word[INSTR_W-1 -: 4];
              operand     <= src_word[OPND_W-1:0];
              issue_pc    <= src_pc;
              issue_valid <= 1'b1;
            end else begin
              opcode      <= 4'd0;
              operand     <= '0;
              issue_valid <= 1'b0;
            end
`ifdef STATIC_JMP_EN
            if (take_jmp) begin
              // Skip the sequential fetch; the BUBBLE slot fetches the target.
              imem_en   <= 1'b0;
              imem_addr <= jmp_target;
              pc        <= jmp_target;
              state     <= BUBBLE;
            end else begin
              imem_en   <= 1'b1;
              imem_addr <= pc;
              pc        <= pc + 1'b1;
              state     <= RUN;
            end
`else
            imem_en   <= 1'b1;
            imem_addr <= pc;
            pc        <= pc + 1'b1;
            state     <= RUN;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, JMP/reset sequences, random run vs queue model.
module tb_instr_fetch_unit;

  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_rdata;
  logic [3:0]    opcode;
  logic [11:0]   operand;
  logic [AW-1:0] issue_pc;
  logic          issue_valid;

  logic [15:0] mem [DEPTH];
  assign imem_rdata = mem[imem_addr];

  instr_fetch_unit #(.ADDR_W(AW), .INSTR_W(16), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .opcode(opcode), .operand(operand), .issue_pc(issue_pc), .issue_valid(issue_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stream of fetched addresses as queues of word addresses.
  bit   m_boot, m_hold;
  int   m_pc;
  int   flight[$];
  int   skid[$];
  bit   e_valid;
  int   e_opc, e_opnd, e_ipc;

  task automatic model_reset();
    m_boot = 1; m_hold = 0; m_pc = 0;
    flight.delete(); skid.delete();
    e_valid = 0; e_opc = 0; e_opnd = 0; e_ipc = 0;
  endtask

  task automatic model_step();
    int src[$];
    int a;
    logic [15:0] w;
    bit jumped;
    if (m_boot) begin
      flight = {m_pc};
      m_pc = (m_pc + 1) % DEPTH;
      m_boot = 0;
    end else if (redirect) begin
      flight = {int'(redirect_pc)};
      m_pc = (int'(redirect_pc) + 1) % DEPTH;
      skid.delete();
      m_hold = 0;
      e_valid = 0; e_opc = 0; e_opnd = 0;
    end else if (stall) begin
      if (!m_hold) begin
        skid = flight;
        flight.delete();
        m_hold = 1;
      end
    end else begin
      if (m_hold) src = skid; else src = flight;
      jumped = 0;
      if (src.size() > 0) begin
        a = src[0];
        w = mem[a];
        e_valid = 1; e_opc = int'(w[15:12]); e_opnd = int'(w[11:0]); e_ipc = a;
`ifdef STATIC_JMP_EN
        if (w[15:12] == 4'hF) begin
          jumped = 1;
          m_pc = int'(w[AW-1:0]);
        end
`endif
      end else begin
        e_valid = 0; e_opc = 0; e_opnd = 0;
      end
      skid.delete();
      m_hold = 0;
      flight.delete();
      if (!jumped) begin
        flight = {m_pc};
        m_pc = (m_pc + 1) % DEPTH;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit check);
    rst = 1; stall = 0; redirect = 0; redirect_pc = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    if (check) begin
      chk("rst_valid", int'(issue_valid), 0);
      chk("rst_opcode", int'(opcode), 0);
      chk("rst_operand", int'(operand), 0);
      chk("rst_issue_pc", int'(issue_pc), 0);
      chk("rst_imem_en", int'(imem_en), 0);
      chk("rst_imem_addr", int'(imem_addr), 0);
    end
    rst = 0;
  endtask

  typedef struct {
    bit          s;
    bit          r;
    logic [7:0]  rpc;
    bit          v;
    logic [7:0]  pc;
  } vec_t;

  function automatic vec_t mk(input bit s, input bit r, input int rpc, input bit v, input int pc);
    vec_t t;
    t.s = s; t.r = r; t.rpc = 8'(rpc); t.v = v; t.pc = 8'(pc);
    return t;
  endfunction

  vec_t tbl[31];

  task automatic expect_issue(input string name, input bit v, input int pc, input int opc, input int opnd);
    chk({name, "_valid"}, int'(issue_valid), int'(v));
    chk({name, "_opcode"}, int'(opcode), v ? opc : 0);
    chk({name, "_operand"}, int'(operand), v ? opnd : 0);
    if (v) chk({name, "_pc"}, int'(issue_pc), pc);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h1000 | 16'(i);

    // Boot, sequential issue, stall, redirect, stall+redirect, skid clear, wrap.
    tbl[0] = mk(0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) tbl[i] = mk(0, 0, 0, 1, i - 1);
    tbl[9]  = mk(1, 0, 0, 1, 7);
    tbl[10] = mk(1, 0, 0, 1, 7);
    tbl[11] = mk(1, 0, 0, 1, 7);
    tbl[12] = mk(0, 0, 0, 1, 8);
    tbl[13] = mk(0, 0, 0, 1, 9);
    tbl[14] = mk(0, 1, 'h40, 0, 0);
    tbl[15] = mk(0, 0, 0, 1, 'h40);
    tbl[16] = mk(0, 0, 0, 1, 'h41);
    tbl[17] = mk(1, 1, 'h20, 0, 0);
    tbl[18] = mk(1, 0, 0, 0, 0);
    tbl[19] = mk(0, 0, 0, 1, 'h20);
    tbl[20] = mk(0, 0, 0, 1, 'h21);
    tbl[21] = mk(1, 0, 0, 1, 'h21);
    tbl[22] = mk(1, 1, 'h30, 0, 0);
    tbl[23] = mk(0, 0, 0, 1, 'h30);
    tbl[24] = mk(0, 0, 0, 1, 'h31);
    tbl[25] = mk(0, 1, 'hFD, 0, 0);
    tbl[26] = mk(0, 0, 0, 1, 'hFD);
    tbl[27] = mk(0, 0, 0, 1, 'hFE);
    tbl[28] = mk(0, 0, 0, 1, 'hFF);
    tbl[29] = mk(0, 0, 0, 1, 'h00);
    tbl[30] = mk(0, 0, 0, 1, 'h01);

    do_reset(1);
    for (int i = 0; i < 31; i++) begin
      stall = tbl[i].s; redirect = tbl[i].r; redirect_pc = tbl[i].rpc;
      tick();
      expect_issue($sformatf("vec%0d", i), tbl[i].v, int'(tbl[i].pc), 1, int'(tbl[i].pc));
    end
    stall = 0; redirect = 0;

    // JMP at word 3 targeting 0x10.
    mem[3] = 16'hF010;
    do_reset(0);
    tick();
    expect_issue("jmp_boot", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_issue($sformatf("jmp_seq%0d", i), 1, i, 1, i);
    end
    tick();
    expect_issue("jmp_issue", 1, 3, 'hF, 'h010);
    tick();
`ifdef STATIC_JMP_EN
    expect_issue("jmp_bubble", 0, 0, 0, 0);
    tick();
    expect_issue("jmp_target", 1, 'h10, 1, 'h10);
    tick();
    expect_issue("jmp_target1", 1, 'h11, 1, 'h11);
`else
    expect_issue("jmp_pass4", 1, 4, 1, 4);
    tick();
    expect_issue("jmp_pass5", 1, 5, 1, 5);
`endif
    mem[3] = 16'h1003;

    // Asynchronous reset mid-run clears outputs without waiting for a clock edge.
    #1 rst = 1;
    #1;
    chk("async_valid", int'(issue_valid), 0);
    chk("async_opcode", int'(opcode), 0);
    chk("async_issue_pc", int'(issue_pc), 0);
    chk("async_imem_en", int'(imem_en), 0);
    chk("async_imem_addr", int'(imem_addr), 0);

    // Random run against the model.
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
    do_reset(1);
    for (int c = 0; c < 3000; c++) begin
      tick();
      chk("rnd_valid", int'(issue_valid), int'(e_valid));
      chk("rnd_opcode", int'(opcode), e_opc);
      chk("rnd_operand", int'(operand), e_opnd);
      if (e_valid) chk("rnd_issue_pc", int'(issue_pc), e_ipc);
      chk("rnd_imem_en", int'(imem_en), (flight.size() > 0) ? 1 : 0);
      if (flight.size() > 0) chk("rnd_imem_addr", int'(imem_addr), flight[0]);
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = AW'($urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
